// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end: PC, imem handshake,
// PC-tagged instruction FIFO and branch redirect/flush.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            iCLK,
  input  logic            iRST,
  output logic            oIMEM_REQ,
  output logic [PC_W-1:0] oIMEM_ADDR,
  input  logic            iIMEM_GNT,
  input  logic            iIMEM_RVALID,
  input  logic [31:0]     iIMEM_RDATA,
  input  logic            iBR_VALID,
  input  logic [31:0]     iBR_TARGET,
  output logic            oIR_VALID,
  output logic [31:0]     oIR,
  output logic [PC_W-1:0] oPC,
  input  logic            iIR_READY,
  output logic            oMISALIGN
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     ir_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];

  logic          br_ok;
  logic          space;
  logic          hs;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An outstanding request reserves a FIFO slot.
  always_comb begin
    occ   = {1'b0, count_q}
          + {{CW{1'b0}}, state_q == S_WAIT};
    space = occ < (CW + 1)'(DEPTH);
    br_ok = iBR_VALID
          & (iBR_TARGET[1:0] == 2'b00);
  end

  assign oIMEM_REQ  = ~iRST
                    & (state_q == S_REQ)
                    & space
                    & ~iBR_VALID;
  assign oIMEM_ADDR = fetch_pc_q;
  assign hs         = oIMEM_REQ & iIMEM_GNT;

  assign oIR_VALID  = (count_q != '0);
  assign oIR        = oIR_VALID
                    ? ir_mem_q[rd_ptr_q] : '0;
  assign oPC        = oIR_VALID
                    ? pc_mem_q[rd_ptr_q] : '0;
  assign oMISALIGN  = misalign_q;

  assign push = (state_q == S_WAIT)
              & iIMEM_RVALID & ~br_ok;
  assign pop  = oIR_VALID & iIR_READY;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    misalign_d = iBR_VALID
               & (iBR_TARGET[1:0] != 2'b00);

    unique case (1'b1)
      state_q == S_REQ: begin
        if (hs) begin
          fetch_pc_d = fetch_pc_q + PC_W'(4);
          req_pc_d   = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      state_q == S_WAIT: begin
        if (iIMEM_RVALID)
          state_d = S_REQ;
        else if (br_ok)
          state_d = S_DROP;
      end
      state_q == S_DROP: begin
        if (iIMEM_RVALID)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (br_ok) begin
      fetch_pc_d = iBR_TARGET[PC_W-1:0];
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      unique case (1'b1)
        push & ~pop: begin
          count_d  = count_q + CW'(1);
          wr_ptr_d = nxt(wr_ptr_q);
        end
        ~push & pop: begin
          count_d  = count_q - CW'(1);
          rd_ptr_d = nxt(rd_ptr_q);
        end
        push & pop: begin
          wr_ptr_d = nxt(wr_ptr_q);
          rd_ptr_d = nxt(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else if (push) begin
      ir_mem_q[wr_ptr_q] <= iIMEM_RDATA;
      pc_mem_q[wr_ptr_q] <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder,
// PC/IR scoreboard and direct output checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [7:0]  addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        ir_valid;
  logic [31:0] ir;
  logic [7:0]  pc;
  logic        ready;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int budget = 0;
  int lat    = 1;

  logic [39:0] sb [$];
  logic [7:0]  gnt_log [$];

  assign gnt = (budget != 0);

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W(8), .RESET_PC(8'h00), .DEPTH(2)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .oIMEM_REQ(req),
    .oIMEM_ADDR(addr),
    .iIMEM_GNT(gnt),
    .iIMEM_RVALID(rvalid),
    .iIMEM_RDATA(rdata),
    .iBR_VALID(br_valid),
    .iBR_TARGET(br_target),
    .oIR_VALID(ir_valid),
    .oIR(ir),
    .oPC(pc),
    .iIR_READY(ready),
    .oMISALIGN(misalign)
  );

  // Memory: word at address a is 0x1000_0000 | a.
  initial begin
    logic       hs_s;
    logic [7:0] a_s;
    logic       pend;
    int         cnt;
    logic [7:0] paddr;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      hs_s = req & gnt;
      a_s  = addr;
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          rvalid = 1'b1;
          rdata  = 32'h1000_0000 | {24'h0, paddr};
          pend   = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (hs_s) begin
        pend   = 1'b1;
        cnt    = lat;
        paddr  = a_s;
        budget = budget - 1;
        gnt_log.push_back(a_s);
      end
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst && ir_valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra act pc=%h ir=%h exp none",
                 pc, ir);
      end else begin
        e = sb.pop_front();
        if ({pc, ir} !== e) begin
          errors++;
          $display("FAIL sb_pop act=%h exp=%h",
                   {pc, ir}, e);
        end
      end
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic exp_push(input logic [7:0] p);
    sb.push_back({p, 32'h1000_0000 | {24'h0, p}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk({n, "_drain"}, sb.size(), 0);
    tick();
  endtask

  task automatic chk_log(input int i,
                         input logic [7:0] e);
    if (gnt_log.size() > i)
      chk($sformatf("grant%0d", i), gnt_log[i], e);
    else
      chk($sformatf("grant%0d_missing", i),
          gnt_log.size(), i + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=done");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    rvalid    = 1'b0;
    rdata     = '0;
    br_valid  = 1'b0;
    br_target = '0;
    ready     = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mis", misalign, 0);
    @(negedge clk);
    chk("rst_req2", req, 0);

    // Stream three words
    tick();
    rst = 1'b0;
    exp_push(8'h00);
    exp_push(8'h04);
    exp_push(8'h08);
    budget = 3;
    drain("s1");
    chk_log(0, 8'h00);
    chk_log(1, 8'h04);
    chk_log(2, 8'h08);

    // Back-pressure fills the FIFO
    ready = 1'b0;
    exp_push(8'h0C);
    exp_push(8'h10);
    exp_push(8'h14);
    budget = 3;
    repeat (10) @(negedge clk);
    chk("full_req", req, 0);
    chk("full_valid", ir_valid, 1);
    chk("full_pc", pc, 8'h0C);
    chk("full_grants", gnt_log.size(), 5);
    tick();
    ready = 1'b1;
    drain("s2");
    chk_log(5, 8'h14);

    // Redirect while waiting, late response
    lat = 2;
    exp_push(8'h40);
    budget = 2;
    tick();
    br_valid  = 1'b1;
    br_target = 32'h40;
    @(negedge clk);
    chk("s3_br_req", req, 0);
    tick();
    br_valid = 1'b0;
    @(negedge clk);
    chk("s3_drop_req", req, 0);
    chk("s3_drop_valid", ir_valid, 0);
    drain("s3");
    chk_log(6, 8'h18);
    chk_log(7, 8'h40);

    // Redirect coincident with response
    lat = 1;
    exp_push(8'h20);
    budget = 2;
    tick();
    br_valid  = 1'b1;
    br_target = 32'h20;
    tick();
    br_valid = 1'b0;
    drain("s4");
    chk_log(8, 8'h44);
    chk_log(9, 8'h20);

    // Misaligned target is ignored
    br_valid  = 1'b1;
    br_target = 32'h42;
    @(negedge clk);
    chk("mis_c0", misalign, 0);
    chk("mis_req", req, 0);
    tick();
    br_valid = 1'b0;
    @(negedge clk);
    chk("mis_c1", misalign, 1);
    @(negedge clk);
    chk("mis_c2", misalign, 0);
    tick();
    exp_push(8'h24);
    budget = 1;
    drain("s5");
    chk_log(10, 8'h24);

    // PC wrap at 2^8
    br_valid  = 1'b1;
    br_target = 32'hFC;
    tick();
    br_valid = 1'b0;
    exp_push(8'hFC);
    exp_push(8'h00);
    budget = 2;
    drain("s6");
    chk_log(11, 8'hFC);
    chk_log(12, 8'h00);
    chk("wrap_addr", addr, 8'h04);

    // Reset in the middle of a transaction
    ready  = 1'b0;
    budget = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_valid) break;
    end
    chk("pre_rst_valid", ir_valid, 1);
    chk("pre_rst_pc", pc, 8'h04);
    tick();
    lat    = 3;
    budget = 1;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_req", req, 0);
    chk("arst_valid", ir_valid, 0);
    chk("arst_ir", ir, 0);
    chk("arst_pc", pc, 0);
    @(negedge clk);
    chk("arst_req2", req, 0);
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req", req, 1);
    chk("post_rst_addr", addr, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("late_rv_valid", ir_valid, 0);
    tick();
    lat = 1;
    exp_push(8'h00);
    budget = 1;
    drain("s7");
    chk_log(13, 8'h04);
    chk_log(14, 8'h08);
    chk_log(15, 8'h00);
    chk("grant_total", gnt_log.size(), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the RV32I core.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned instructions in a small FIFO, paired with their PC, and presents them to decode.
- Consumes the branch target produced by the B-type execute path. On a redirect it flushes the buffer, drops any in-flight response, and restarts fetch at the new PC.

Parameters:
PC_W, 8, PC and instruction-address width; all PC arithmetic is modulo 2^PC_W.
RESET_PC, 0, fetch PC loaded on reset; must be word aligned.
DEPTH, 2, instruction FIFO entries (2..8).

Ports:
iCLK  in  1  core clock, rising edge.
iRST  in  1  asynchronous reset, active-high.
oIMEM_REQ  out  1  fetch request valid.
oIMEM_ADDR  out  PC_W  byte address of the requested word.
iIMEM_GNT  in  1  request accepted in the current cycle (handshake = REQ & GNT).
iIMEM_RVALID  in  1  response valid; responses arrive in order, at least 1 cycle after grant.
iIMEM_RDATA  in  32  instruction word.
iBR_VALID  in  1  redirect strobe, one cycle.
iBR_TARGET  in  32  redirect target; low PC_W bits are used.
oIR_VALID  out  1  FIFO head valid.
oIR  out  32  head instruction; 0 when empty.
oPC  out  PC_W  head PC; 0 when empty.
iIR_READY  in  1  decode accepts the head (pop = oIR_VALID & iIR_READY).
oMISALIGN  out  1  one-cycle pulse: redirect target has bits[1:0] != 0.

Behaviour:
- Reset (async, active-high; takes effect immediately, independent of clock):
  - fetch_pc = RESET_PC, FIFO count = 0, state = S_REQ.
  - oIMEM_REQ = 0, oIR_VALID = 0, oIR = 0, oPC = 0, oMISALIGN = 0.
  - Any in-flight response is forgotten; reset mid-transaction needs no drain.
- At most one outstanding request at a time.
- Space condition: count + (state == S_WAIT) < DEPTH.
- States:
  - S_REQ: oIMEM_REQ = space & ~iBR_VALID (combinational); oIMEM_ADDR = fetch_pc.
    - On handshake: fetch_pc += 4 (wraps at 2^PC_W); capture PC into req_pc; go to S_WAIT.
    - oIMEM_ADDR holds stable while REQ is high and GNT is low.
  - S_WAIT: on RVALID, push {req_pc, RDATA} into the FIFO; go to S_REQ. Next request no earlier than the following cycle.
  - S_DROP: on RVALID, discard the data; go to S_REQ.
- Redirect (iBR_VALID = 1, aligned target):
  - At that edge: FIFO cleared (count = 0), fetch_pc = target[PC_W-1:0].
  - From S_WAIT without RVALID in the same cycle: go to S_DROP.
  - From S_WAIT with RVALID in the same cycle: data discarded; go to S_REQ.
  - From S_DROP: stay in S_DROP.
  - From S_REQ: no request issued that cycle; stay in S_REQ.
  - First request at the new target is asserted the next cycle.
  - A pop in the redirect cycle still counts as consumed by decode; the flush wins for FIFO state.
- Misaligned redirect (target[1:0] != 0): oMISALIGN pulses the next cycle; redirect ignored; fetch continues unchanged.
- FIFO:
  - Push and pop in the same cycle are allowed; count unchanged.
  - Push into a full FIFO cannot occur, by the space rule.
  - Pop of an empty FIFO is ignored.
  - oIR_VALID = (count != 0); head outputs are registered (FIFO storage).
- Latency: a grant at cycle T with RVALID at T+k gives oIR_VALID at T+k+1 (FIFO previously empty).
- Throughput: one instruction per 2 cycles at single-cycle memory latency.

Test Plan:
- Reset, then GNT tied 1 and RVALID 1 cycle after grant, READY=1 → addresses 0x00, 0x04, 0x08 issued; oPC/oIR stream 0x00/word0, 0x04/word1 in order; no REQ during reset.
- READY=0 with DEPTH=2 → after 2 pushes oIMEM_REQ stays 0, count=2; raise READY → head pops, REQ resumes at 0x08.
- Redirect to 0x40 while in S_WAIT, RVALID 2 cycles later → that response dropped, FIFO empty, next oIMEM_ADDR=0x40, next oPC=0x40.
- Redirect to 0x20 in the same cycle as RVALID → data not pushed; next request at 0x20.
- iBR_TARGET=0x42 → oMISALIGN pulses once; fetch_pc sequence unaffected.
- fetch_pc=0xFC, PC_W=8 → after grant oIMEM_ADDR=0x00 (wrap); assert iRST mid-S_WAIT → all outputs 0 immediately; late RVALID ignored; restart at RESET_PC.
